// File: rtl/mul_sequencer.sv
// mul_sequencer: issue-side sequencer for the 32-cycle shift-add multiplier serving the RISC-V
// M-extension ops MUL, MULH, MULHSU and MULHU.
//
// One request is accepted at a time over a valid/ready handshake. Signed operands are turned into
// magnitudes, the multiplier is run unsigned, and the 64-bit product is negated afterwards when the
// operand signs differ. The low or high half is returned with the request tag. A one-entry cache
// remembers the last completed product so that a back-to-back op on the same operands (e.g. MULHU
// after MUL) answers without touching the multiplier.
//
// Ports
//   clock, reset_n           clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready      request handshake; req_ready only in IDLE and not while flush is high
//   req_op                   00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   req_rs1, req_rs2         operands
//   req_tag                  returned unchanged on resp_tag
//   flush                    abort the in-flight request; its response is dropped
//   resp_valid/resp_ready    response handshake
//   resp_data, resp_tag      selected 32-bit result and its tag
//   resp_err                 multiplier timeout; resp_data is forced to 0
//   mult_enable              multiplier run enable (low clears the multiplier's internal index)
//   mult_a, mult_b           operand magnitudes, stable from LAUNCH through DRAIN
//   mult_signed_a/_b         tied 0, the multiplier always runs unsigned
//   mult_lower/_higher       product bits [31:0] / [63:32]
//   mult_valid               multiplier done, held until mult_enable drops
//   busy                     sequencer not in IDLE
module mul_sequencer #(
  parameter int unsigned TAG_W    = 4,
  parameter int unsigned CACHE_EN = 1,
  parameter int unsigned TIMEOUT  = 40
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_rs1,
  input  logic [31:0]      req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_err,
  output logic             mult_enable,
  output logic [31:0]      mult_a,
  output logic [31:0]      mult_b,
  output logic             mult_signed_a,
  output logic             mult_signed_b,
  input  logic [31:0]      mult_lower,
  input  logic [31:0]      mult_higher,
  input  logic             mult_valid,
  output logic             busy
);

  localparam logic [1:0] OpMul    = 2'b00;
  localparam logic [1:0] OpMulh   = 2'b01;
  localparam logic [1:0] OpMulhsu = 2'b10;

  localparam int unsigned     CntW    = $clog2(TIMEOUT + 1);
  // Last WAIT cycle index before the abort fires; WAIT lasts at most TIMEOUT cycles.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWait,
    StDrain,
    StResp
  } state_e;

  state_e state_q, state_d;

  // Request registers
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic             sa_q, sb_q;
  logic [31:0]      a_q, b_q;
  logic [63:0]      prod_q;     // unsigned product of the magnitudes
  logic             err_q;
  logic             drop_q;     // flushed while the multiplier was running: no response
  logic [CntW-1:0]  cnt_q;

  // One-entry cache. Magnitude plus sign flag is a bijection of the raw operand, so comparing
  // magnitudes and flags is the same as comparing the raw rs1/rs2 under the same sign rules.
  logic             c_valid_q;
  logic [31:0]      c_a_q, c_b_q;
  logic             c_sa_q, c_sb_q;
  logic [63:0]      c_prod_q;

  // Incoming request decode
  logic        in_sa, in_sb;
  logic [31:0] in_a, in_b;
  logic        cache_on;
  logic        hit;
  logic        accept;
  logic        capture;
  logic        timeout;
  logic        mult_active;

  always_comb begin
    in_sa = req_rs1[31] & ((req_op == OpMulh) | (req_op == OpMulhsu));
    in_sb = req_rs2[31] & (req_op == OpMulh);
    // 0x80000000 maps onto itself and is read as 2^31 by the unsigned multiplier.
    in_a  = in_sa ? (~req_rs1 + 32'd1) : req_rs1;
    in_b  = in_sb ? (~req_rs2 + 32'd1) : req_rs2;
  end

  assign cache_on    = (CACHE_EN != 0);
  assign hit         = cache_on & c_valid_q & (in_a == c_a_q) & (in_b == c_b_q) &
                       (in_sa == c_sa_q) & (in_sb == c_sb_q);
  assign accept      = (state_q == StIdle) & req_valid & ~flush;
  assign mult_active = (state_q == StLaunch) | (state_q == StWait);
  assign capture     = (state_q == StWait) & ~flush & mult_valid;
  assign timeout     = (state_q == StWait) & ~flush & ~mult_valid & (cnt_q == CntLast);

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = hit ? StResp : StLaunch;
        end
      end
      StLaunch: begin
        state_d = flush ? StDrain : StWait;
      end
      StWait: begin
        if (flush || mult_valid || timeout) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (flush) begin
          state_d = StIdle;
        end else if (!mult_valid) begin
          state_d = drop_q ? StIdle : StResp;
        end
      end
      StResp: begin
        // A flush here drops the response even if resp_ready happens to be high.
        if (flush || resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready   = 1'b0;
    mult_enable = 1'b0;
    resp_valid  = 1'b0;
    busy        = 1'b1;
    case (state_q)
      StIdle: begin
        req_ready = ~flush;
        busy      = 1'b0;
      end
      StWait:  mult_enable = 1'b1;
      StResp:  resp_valid  = 1'b1;
      default: ;
    endcase
  end

  // Request / result datapath
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      op_q   <= 2'b00;
      tag_q  <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      prod_q <= '0;
      err_q  <= 1'b0;
      drop_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      if (accept) begin
        op_q   <= req_op;
        tag_q  <= req_tag;
        sa_q   <= in_sa;
        sb_q   <= in_sb;
        a_q    <= in_a;
        b_q    <= in_b;
        err_q  <= 1'b0;
        drop_q <= 1'b0;
        cnt_q  <= '0;
        if (hit) begin
          prod_q <= c_prod_q;
        end
      end
      if (flush && mult_active) begin
        drop_q <= 1'b1;
      end
      if (state_q == StWait) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (capture) begin
        prod_q <= {mult_higher, mult_lower};
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  // Product cache: written only by a completed, unflushed product; a timeout invalidates it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      c_valid_q <= 1'b0;
      c_a_q     <= '0;
      c_b_q     <= '0;
      c_sa_q    <= 1'b0;
      c_sb_q    <= 1'b0;
      c_prod_q  <= '0;
    end else begin
      if (capture && cache_on) begin
        c_valid_q <= 1'b1;
        c_a_q     <= a_q;
        c_b_q     <= b_q;
        c_sa_q    <= sa_q;
        c_sb_q    <= sb_q;
        c_prod_q  <= {mult_higher, mult_lower};
      end else if (timeout) begin
        c_valid_q <= 1'b0;
      end
    end
  end

  // Sign fix-up and half select
  logic        neg;
  logic [63:0] prod_signed;

  always_comb begin
    neg         = sa_q ^ sb_q;
    prod_signed = neg ? (~prod_q + 64'd1) : prod_q;
    if (err_q) begin
      resp_data = '0;
    end else if (op_q == OpMul) begin
      resp_data = prod_signed[31:0];
    end else begin
      resp_data = prod_signed[63:32];
    end
  end

  assign resp_tag      = tag_q;
  assign resp_err      = err_q;
  assign mult_a        = a_q;
  assign mult_b        = b_q;
  assign mult_signed_a = 1'b0;
  assign mult_signed_b = 1'b0;

endmodule
